// File: rtl/escalonador_decod_4_16_if.sv
// Request/grant bundle between requesters and the round-robin sequencer.
// master = request side, slave = sequencer.
interface escalonador_decod_4_16_if;
    logic        en;
    logic [15:0] req;
    logic [3:0]  a;
    logic [15:0] gnt_n;
    logic        valid;
    logic        expirou;

    modport master (
        output en, req,
        input  a, gnt_n, valid, expirou
    );

    modport slave (
        input  en, req,
        output a, gnt_n, valid, expirou
    );
endinterface

// File: rtl/escalonador_decod_4_16.sv
// Round-robin sequencer for 16 requesters behind a 4->16 one-cold decoder.
// Optional hold timeout: define ESCALONADOR_TIMEOUT_EN.
module escalonador_decod_4_16 #(
    parameter int unsigned HOLD_MAX = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    escalonador_decod_4_16_if.slave   bus
);
    typedef enum logic [1:0] {
        OCIOSO,
        CONCEDE,
        LIBERA
    } estado_t;

    estado_t    estado, estado_nx;
    logic [3:0] ptr, ptr_nx;
    logic [3:0] a_q, a_nx;
    logic [3:0] idx;
    logic [3:0] venc;
    logic       achou;
    logic       estouro;
    logic       valid_q;

`ifdef ESCALONADOR_TIMEOUT_EN
    logic [7:0] cnt, cnt_nx;
    logic       expirou_q, expirou_nx;

    assign estouro = (cnt == 8'(HOLD_MAX));
`else
    assign estouro = 1'b0;
`endif

    // Scan from ptr upward; iterating backwards lets the nearest hit win.
    always_comb begin
        venc  = ptr;
        achou = 1'b0;
        idx   = ptr;
        for (int i = 15; i >= 0; i--) begin
            idx = ptr + 4'(i);
            if (bus.req[idx]) begin
                venc  = idx;
                achou = 1'b1;
            end
        end
    end

    always_comb begin
        estado_nx  = estado;
        ptr_nx     = ptr;
        a_nx       = a_q;
`ifdef ESCALONADOR_TIMEOUT_EN
        cnt_nx     = cnt;
        expirou_nx = 1'b0;
`endif
        unique case (estado)
            OCIOSO, LIBERA: begin
                if (bus.en && achou) begin
                    estado_nx = CONCEDE;
                    a_nx      = venc;
                    ptr_nx    = venc + 4'd1;
`ifdef ESCALONADOR_TIMEOUT_EN
                    cnt_nx    = 8'd1;
`endif
                end else begin
                    estado_nx = OCIOSO;
                end
            end
            CONCEDE: begin
                if (!bus.req[a_q]) begin
                    estado_nx = LIBERA;
                end else if (estouro) begin
                    estado_nx = LIBERA;
`ifdef ESCALONADOR_TIMEOUT_EN
                    expirou_nx = 1'b1;
`endif
                end else begin
`ifdef ESCALONADOR_TIMEOUT_EN
                    cnt_nx = cnt + 8'd1;
`endif
                end
            end
            default: estado_nx = OCIOSO;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            estado  <= OCIOSO;
            ptr     <= 4'd0;
            a_q     <= 4'd0;
            valid_q <= 1'b0;
        end else begin
            estado  <= estado_nx;
            ptr     <= ptr_nx;
            a_q     <= a_nx;
            valid_q <= (estado_nx == CONCEDE);
        end
    end

`ifdef ESCALONADOR_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= 8'd0;
            expirou_q <= 1'b0;
        end else begin
            cnt       <= cnt_nx;
            expirou_q <= expirou_nx;
        end
    end

    assign bus.expirou = expirou_q;
`else
    assign bus.expirou = 1'b0;
`endif

    assign bus.a     = a_q;
    assign bus.valid = valid_q;
    assign bus.gnt_n = ~({15'd0, valid_q} << a_q);
endmodule
